// File: rtl/ex_wb_register.sv
// EX/WB pipeline register: captures execute-stage results for write-back.
// Supports hold (stall) and bubble insertion (flush); flush wins over stall.
module ex_wb_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BANK_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] regs_bank_in,
    input  logic [DATA_W-1:0] mux2_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] regC_adress_in,
    input  logic              write_inst_in,
    input  logic              stall,
    input  logic              flush,
    output logic [BANK_W-1:0] regs_bank_out,
    output logic [DATA_W-1:0] mux2_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [ADDR_W-1:0] regC_adress_out,
    output logic              write_inst_out
);

    logic [BANK_W-1:0] regs_bank_d, regs_bank_q;
    logic [DATA_W-1:0] mux2_d,      mux2_q;
    logic [DATA_W-1:0] pc_d,        pc_q;
    logic [ADDR_W-1:0] regc_addr_d, regc_addr_q;
    logic              write_d,     write_q;

    always_comb begin
        regs_bank_d = regs_bank_q;
        mux2_d      = mux2_q;
        pc_d        = pc_q;
        regc_addr_d = regc_addr_q;
        write_d     = write_q;
        if (flush) begin
            // Bubble: write_inst cleared makes WB a no-op.
            regs_bank_d = '0;
            mux2_d      = '0;
            pc_d        = '0;
            regc_addr_d = '0;
            write_d     = 1'b0;
        end else if (!stall) begin
            regs_bank_d = regs_bank_in;
            mux2_d      = mux2_in;
            pc_d        = pc_in;
            regc_addr_d = regC_adress_in;
            write_d     = write_inst_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_bank_q <= '0;
            mux2_q      <= '0;
            pc_q        <= '0;
            regc_addr_q <= '0;
            write_q     <= 1'b0;
        end else begin
            regs_bank_q <= regs_bank_d;
            mux2_q      <= mux2_d;
            pc_q        <= pc_d;
            regc_addr_q <= regc_addr_d;
            write_q     <= write_d;
        end
    end

    assign regs_bank_out   = regs_bank_q;
    assign mux2_out        = mux2_q;
    assign pc_out          = pc_q;
    assign regC_adress_out = regc_addr_q;
    assign write_inst_out  = write_q;

endmodule

// File: tb/tb_ex_wb_register.sv
// Directed bench for ex_wb_register: reset, capture, update, stall, flush,
// full-width transfer and mid-stream asynchronous reset.
module tb_ex_wb_register;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BANK_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [BANK_W-1:0] regs_bank_in;
    logic [DATA_W-1:0] mux2_in;
    logic [DATA_W-1:0] pc_in;
    logic [ADDR_W-1:0] regC_adress_in;
    logic              write_inst_in;
    logic              stall;
    logic              flush;
    logic [BANK_W-1:0] regs_bank_out;
    logic [DATA_W-1:0] mux2_out;
    logic [DATA_W-1:0] pc_out;
    logic [ADDR_W-1:0] regC_adress_out;
    logic              write_inst_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    ex_wb_register #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BANK_W(BANK_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .regs_bank_in   (regs_bank_in),
        .mux2_in        (mux2_in),
        .pc_in          (pc_in),
        .regC_adress_in (regC_adress_in),
        .write_inst_in  (write_inst_in),
        .stall          (stall),
        .flush          (flush),
        .regs_bank_out  (regs_bank_out),
        .mux2_out       (mux2_out),
        .pc_out         (pc_out),
        .regC_adress_out(regC_adress_out),
        .write_inst_out (write_inst_out)
    );

    // Period 10, first rising edge at t = 5.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic wi, input logic [BANK_W-1:0] bank,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] mux,
                             input logic [DATA_W-1:0] pc);
        check({tag, ".write"}, 64'(write_inst_out), 64'(wi));
        check({tag, ".bank"},  64'(regs_bank_out),  64'(bank));
        check({tag, ".addr"},  64'(regC_adress_out), 64'(addr));
        check({tag, ".mux2"},  64'(mux2_out),       64'(mux));
        check({tag, ".pc"},    64'(pc_out),         64'(pc));
    endtask

    task automatic set_in(input logic wi, input logic [BANK_W-1:0] bank,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] mux,
                          input logic [DATA_W-1:0] pc);
        write_inst_in  = wi;
        regs_bank_in   = bank;
        regC_adress_in = addr;
        mux2_in        = mux;
        pc_in          = pc;
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_in(1'b1, 2'd2, 4'd9, 32'd200, 32'd620);

        // Reset holds outputs at zero with live inputs, including during clk high.
        #1 check_all("rst_low", 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_all("rst_high_phase", 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all("rst_release_no_edge", 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);

        // First edge after release loads inputs.
        tick();
        check_all("capture", 1'b1, 2'd2, 4'd9, 32'd200, 32'd620);
        tick();
        check_all("capture_hold", 1'b1, 2'd2, 4'd9, 32'd200, 32'd620);

        // Input change between edges is invisible until the next edge.
        set_in(1'b0, 2'd3, 4'd12, 32'd160, 32'd450);
        #2 check_all("update_pre_edge", 1'b1, 2'd2, 4'd9, 32'd200, 32'd620);
        tick();
        check_all("update", 1'b0, 2'd3, 4'd12, 32'd160, 32'd450);

        // Stall for two edges, then release.
        set_in(1'b1, 2'd2, 4'd9, 32'd200, 32'd620);
        tick();
        check_all("stall_setup", 1'b1, 2'd2, 4'd9, 32'd200, 32'd620);
        stall = 1'b1;
        set_in(1'b0, 2'd3, 4'd12, 32'd160, 32'd450);
        tick();
        check_all("stall_1", 1'b1, 2'd2, 4'd9, 32'd200, 32'd620);
        tick();
        check_all("stall_2", 1'b1, 2'd2, 4'd9, 32'd200, 32'd620);
        stall = 1'b0;
        tick();
        check_all("stall_release", 1'b0, 2'd3, 4'd12, 32'd160, 32'd450);

        // Flush beats stall.
        set_in(1'b1, 2'd1, 4'd5, 32'h1234_5678, 32'h0000_0abc);
        tick();
        check_all("flush_setup", 1'b1, 2'd1, 4'd5, 32'h1234_5678, 32'h0000_0abc);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        check_all("flush_over_stall", 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Full-width transfer.
        set_in(1'b1, 2'd3, 4'd15, 32'hFFFF_FFFF, 32'h8000_0000);
        tick();
        check_all("full_width", 1'b1, 2'd3, 4'd15, 32'hFFFF_FFFF, 32'h8000_0000);

        // Mid-stream async reset asserted during clk high phase.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_all("rst_midstream", 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b1;
        set_in(1'b1, 2'd2, 4'd7, 32'hDEAD_BEEF, 32'h0000_0100);
        tick();
        check_all("rst_then_stall", 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
        stall = 1'b0;
        tick();
        check_all("rst_then_load", 1'b1, 2'd2, 4'd7, 32'hDEAD_BEEF, 32'h0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
